// File: rtl/demux1to2_8bit_reg.sv
// Registered 1:2 valid/ready stream demultiplexer with one holding entry per output.
// Define DEMUX_CNT_EN to add the per-output delivered-beat counters cnt0/cnt1.
module demux1to2_8bit_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

   slot_t            slot0_p0, slot1_p0;
   logic [WIDTH-1:0] data0_p0, data1_p0;
   logic             acc0, acc1;
   logic             drain0, drain1;

   function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] val);
      return val + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // A full slot whose consumer is ready can take a new beat in the same cycle.
   always_comb begin
      if (in_sel)
         in_ready = (slot1_p0 == EMPTY) | out1_ready;
      else
         in_ready = (slot0_p0 == EMPTY) | out0_ready;
   end

   assign acc0   = in_valid & in_ready & ~in_sel;
   assign acc1   = in_valid & in_ready &  in_sel;
   assign drain0 = (slot0_p0 == FULL) & out0_ready;
   assign drain1 = (slot1_p0 == FULL) & out1_ready;

   // stage p0: per-output entry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_p0 <= EMPTY;
         slot1_p0 <= EMPTY;
         data0_p0 <= '0;
         data1_p0 <= '0;
      end else begin
         case (slot0_p0)
            EMPTY: begin
               if (acc0) begin
                  data0_p0 <= in_data;
                  slot0_p0 <= FULL;
               end
            end
            default: begin
               if (acc0)
                  data0_p0 <= in_data;
               else if (out0_ready)
                  slot0_p0 <= EMPTY;
            end
         endcase
         case (slot1_p0)
            EMPTY: begin
               if (acc1) begin
                  data1_p0 <= in_data;
                  slot1_p0 <= FULL;
               end
            end
            default: begin
               if (acc1)
                  data1_p0 <= in_data;
               else if (out1_ready)
                  slot1_p0 <= EMPTY;
            end
         endcase
      end
   end

   assign out0_valid = (slot0_p0 == FULL);
   assign out1_valid = (slot1_p0 == FULL);
   assign out0_data  = data0_p0;
   assign out1_data  = data1_p0;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt0_p0, cnt1_p0;

   // stage p0: delivered-beat counters, wrapping at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_p0 <= '0;
         cnt1_p0 <= '0;
      end else begin
         if (drain0) cnt0_p0 <= wrap_inc(cnt0_p0);
         if (drain1) cnt1_p0 <= wrap_inc(cnt1_p0);
      end
   end

   assign cnt0 = cnt0_p0;
   assign cnt1 = cnt1_p0;
`else
   logic unused_drain;
   assign unused_drain = drain0 ^ drain1 ^ (|wrap_inc('0));
`endif

endmodule

// File: tb/tb_demux1to2_8bit_reg.sv
// Scoreboard bench for demux1to2_8bit_reg: the driver queues accepted beats per output,
// an independent monitor models slot occupancy and checks handshakes, data order and counters.
module tb_demux1to2_8bit_reg;
   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, in_sel;
   logic [WIDTH-1:0] in_data;
   logic             out0_valid, out0_ready, out1_valid, out1_ready;
   logic [WIDTH-1:0] out0_data, out1_data;
`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt0, cnt1;
`endif

   demux1to2_8bit_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef DEMUX_CNT_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   always #5 clk = ~clk;

   int               checks = 0;
   int               failures = 0;
   logic [WIDTH-1:0] exp_q0[$];
   logic [WIDTH-1:0] exp_q1[$];
   bit               exp_v0 = 1'b0, exp_v1 = 1'b0;
   logic [CNT_W-1:0] exp_cnt0 = '0, exp_cnt1 = '0;
   bit               mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // One cycle of stimulus; inputs change #1 after posedge, acceptance judged at negedge.
   task automatic send(input bit v, input bit sel, input logic [WIDTH-1:0] d,
                       input bit r0, input bit r1, output bit acc);
      in_valid = v; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
      @(negedge clk);
      acc = v && in_ready;
      if (acc) begin
         if (sel) exp_q1.push_back(d);
         else     exp_q0.push_back(d);
      end
      @(posedge clk); #1;
   endtask

   // Monitor: each output holds at most one beat; a slot is occupied after an accept
   // and freed by a drain, and a beat can enter a slot that drains in the same cycle.
   initial begin : monitor
      bit er, a0, a1, d0, d1, active;
      forever begin
         @(negedge clk);
         active = rst_n && mon_en;
         a0 = 1'b0; a1 = 1'b0; d0 = 1'b0; d1 = 1'b0;
         if (active) begin
            er = in_sel ? (!exp_v1 || out1_ready) : (!exp_v0 || out0_ready);
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("out0_valid", 32'(out0_valid), 32'(exp_v0));
            chk("out1_valid", 32'(out1_valid), 32'(exp_v1));
            if (exp_v0) begin
               if (exp_q0.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL out0_sb actual=%0h required=<none queued>", out0_data);
               end else chk("out0_data", 32'(out0_data), 32'(exp_q0[0]));
            end
            if (exp_v1) begin
               if (exp_q1.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL out1_sb actual=%0h required=<none queued>", out1_data);
               end else chk("out1_data", 32'(out1_data), 32'(exp_q1[0]));
            end
`ifdef DEMUX_CNT_EN
            chk("cnt0", 32'(cnt0), 32'(exp_cnt0));
            chk("cnt1", 32'(cnt1), 32'(exp_cnt1));
`endif
            d0 = exp_v0 && out0_ready;
            d1 = exp_v1 && out1_ready;
            a0 = in_valid && er && !in_sel;
            a1 = in_valid && er && in_sel;
         end
         @(posedge clk);
         if (active && rst_n) begin
            if (d0) begin
               if (exp_q0.size() != 0) void'(exp_q0.pop_front());
               exp_cnt0 = exp_cnt0 + 1'b1;
            end
            if (d1) begin
               if (exp_q1.size() != 0) void'(exp_q1.pop_front());
               exp_cnt1 = exp_cnt1 + 1'b1;
            end
            exp_v0 = a0 || (exp_v0 && !d0);
            exp_v1 = a1 || (exp_v1 && !d1);
         end
      end
   end

   initial begin : stimulus
      bit acc;
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out0_valid", 32'(out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("rst_out0_data", 32'(out0_data), 32'd0);
      chk("rst_out1_data", 32'(out1_data), 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Steering, one-cycle latency
      send(1, 0, 8'hAA, 1, 1, acc);
      chk("t2_acc_aa", 32'(acc), 32'd1);
      chk("t2_out0_valid", 32'(out0_valid), 32'd1);
      chk("t2_out0_data", 32'(out0_data), 32'hAA);
      send(1, 1, 8'h55, 1, 1, acc);
      chk("t2_out1_data", 32'(out1_data), 32'h55);
      chk("t2_out0_drained", 32'(out0_valid), 32'd0);
      send(0, 0, 8'h00, 1, 1, acc);

      // Stall isolation
      send(1, 0, 8'h11, 0, 1, acc);
      chk("t3_acc_11", 32'(acc), 32'd1);
      send(1, 0, 8'h22, 0, 1, acc);
      chk("t3_acc_22_blocked", 32'(acc), 32'd0);
      send(1, 1, 8'h33, 0, 0, acc);
      chk("t3_acc_33", 32'(acc), 32'd1);
      chk("t3_out1_data", 32'(out1_data), 32'h33);
      chk("t3_out0_hold", 32'(out0_data), 32'h11);
      chk("t3_out0_valid", 32'(out0_valid), 32'd1);
      send(1, 1, 8'h44, 0, 0, acc);
      chk("t3_both_full_block", 32'(acc), 32'd0);
      chk("t3_out1_hold", 32'(out1_data), 32'h33);
      send(0, 0, 8'h00, 1, 1, acc);
      send(0, 0, 8'h00, 1, 1, acc);

      // Back-to-back on out1
      for (int i = 1; i <= 8; i++) begin
         send(1, 1, 8'(i), 1, 1, acc);
         chk("t4_acc", 32'(acc), 32'd1);
         chk("t4_out1_data", 32'(out1_data), 32'(i));
      end
      send(0, 0, 8'h00, 1, 1, acc);

      // Simultaneous drain and accept on out0
      send(1, 0, 8'hF0, 0, 1, acc);
      send(1, 0, 8'h0F, 1, 1, acc);
      chk("t5_acc", 32'(acc), 32'd1);
      chk("t5_out0_valid", 32'(out0_valid), 32'd1);
      chk("t5_out0_data", 32'(out0_data), 32'h0F);
      send(0, 0, 8'h00, 1, 1, acc);

      // Randomised traffic
      for (int i = 0; i < 400; i++)
         send(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), 8'($urandom),
              bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 2) != 0), acc);

      // Asynchronous reset mid-run with out0 full
      send(1, 0, 8'h77, 0, 0, acc);
      send(0, 0, 8'h00, 0, 0, acc);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t1_out0_valid", 32'(out0_valid), 32'd0);
      chk("t1_out1_valid", 32'(out1_valid), 32'd0);
`ifdef DEMUX_CNT_EN
      chk("t1_cnt0", 32'(cnt0), 32'd0);
`endif
      exp_q0.delete(); exp_q1.delete();
      exp_v0 = 1'b0; exp_v1 = 1'b0; exp_cnt0 = '0; exp_cnt1 = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

`ifdef DEMUX_CNT_EN
      // Counter wrap: 257 deliveries on out0
      for (int i = 0; i < 257; i++)
         send(1, 0, 8'($urandom), 1, 0, acc);
      send(0, 0, 8'h00, 1, 0, acc);
      chk("t6_cnt0_wrap", 32'(cnt0), 32'd1);
      chk("t6_cnt1", 32'(cnt1), 32'd0);
`endif

      for (int i = 0; i < 100; i++)
         send(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), acc);
      repeat (3) send(0, 0, 8'h00, 1, 1, acc);
      chk("end_out0_idle", 32'(out0_valid), 32'd0);
      chk("end_out1_idle", 32'(out1_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
